mips32_prog_loader: RTL and testbench
=====================================

// Module: mips32_prog_loader
// PURPOSE
//  Upstream boot stage for pipe_MIPS32. Receives a program image as a byte stream,
//  packs it into 32-bit words and writes them into the core's unified memory through a
//  write port. Then pulses core_start (core clears HALTED, PC<=0) and waits for the
//  core's HALTED flag. Takes over the image preload and release that benches now do by hand.
// PARAMETERS
//  ADDR_W  10  memory word-address width; addresses wrap modulo 2**ADDR_W
// PORTS
//  clk1         in   1       single clock, rising edge
//  rst_n        in   1       asynchronous, active-low reset
//  in_valid     in   1       byte available on in_data
//  in_data      in   8       image byte
//  in_ready     out  1       loader accepts byte (transfer = in_valid & in_ready)
//  mem_we       out  1       one-cycle memory write strobe
//  mem_addr     out  ADDR_W  word address for write
//  mem_wdata    out  32      word to write
//  core_start   out  1       one-cycle pulse: core clears HALTED, PC<=0, TAKEN_BRANCH<=0
//  core_halted  in   1       core HALTED flag
//  busy         out  1       high in HDR/DATA/CHK/START/RUN
//  done         out  1       high in DONE
//  error        out  1       high in ERR
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, byte/word counters 0. Reset mid-load abandons the load.
//    Words already written stay in memory.
//  Byte packing: big-endian. 1st byte->[31:24] ... 4th->[7:0]. Gaps in in_valid allowed.
//  States: IDLE, HDR, DATA, CHK (macro only), START, RUN, DONE, ERR.
//   IDLE : in_ready=1. First accepted byte counts as header byte 0 -> HDR.
//   HDR  : collect header word {base[31:16], count[15:0]}. Word address = base[ADDR_W-1:0].
//          count > 2**ADDR_W -> ERR. count==0 -> CHK (macro on) or START.
//          Otherwise -> DATA.
//   DATA : in_ready=1. Each completed word i: the cycle after the 4th byte is accepted,
//          mem_we=1 with mem_addr=(base+i) mod 2**ADDR_W and mem_wdata=word.
//          After word count-1 -> CHK / START.
//   START: in_ready=0. core_start=1 for exactly one cycle -> RUN.
//   RUN  : in_ready=0. Wait for core_halted=1.
//          core_halted is ignored in the START cycle and in the 1st RUN cycle, so a stale
//          HALTED does not end the run. Then -> DONE.
//   DONE : done=1, in_ready=1. An accepted byte is header byte 0 of a new image -> HDR.
//   ERR  : error=1, in_ready=0, no memory writes, no core_start. Exit only via rst_n.
//  in_ready is deasserted in the cycle mem_we is high.
//    Throughput: at most 1 byte/cycle, 1 stall cycle per word.
//  The index counter is 17 bits, so count=65535 never aliases.
//    Address wrap past 2**ADDR_W-1 to 0 is legal.
//  mem_we and core_start are never high in the same cycle.
// CONFIGURATION
//  PROG_LOADER_CHECKSUM_EN defined:
//    - A 32-bit trailer word follows the data words (state CHK).
//    - Expected value = XOR of all data words (0 when count==0).
//    - Match -> START. Mismatch -> ERR.
//    - Trailer is never written to memory.
//  Not defined: no CHK state. After the last data word go directly to START.
// TESTING
//  T1 header 0x0000_0008 + 8 words 28010078,0c631800,20220000,0c631800,2842002d,
//     0c631800,24220001,0c000000:
//     - 8 writes, addr 0..7, data as sent.
//     - Then 1 core_start pulse.
//     - Model raises core_halted 40 cycles later -> done=1, busy=0.
//  T2 header 0x03FE_0003, words A,B,C -> writes at 0x3FE,0x3FF,0x000.
//  T3 header 0x0000_0000 -> no mem_we.
//     - Macro off: core_start 1 cycle after header.
//     - Macro on: trailer 0 required first.
//  T4 header 0x0000_0401 (1025 > 1024) -> error=1.
//     - No mem_we or core_start ever; only rst_n clears it.
//  T5 random in_valid gaps plus rst_n pulse after 2 of 4 words:
//     - All outputs 0 during reset.
//     - Fresh 2-word image then loads correctly at its base.
//  T6 macro on, 2 words 0x1,0x2:
//     - Trailer 0x3 -> START.
//     - Trailer 0x4 -> ERR, no core_start.

Source files
------------

// File: rtl/mips32_prog_loader.sv
// mips32_prog_loader: boot stage for pipe_MIPS32.
//   Accepts a program image as a byte stream, packs big-endian 32-bit words and writes
//   them into the core's unified memory. It then pulses core_start and waits for the core's
//   HALTED flag.
//   Image format: header word {base[31:16], count[15:0]}, then count data words.
//   When PROG_LOADER_CHECKSUM_EN is defined, a 32-bit trailer follows the data words. The
//   trailer must equal the XOR of the data words; a mismatch ends in the error state.
// Parameters:
//   ADDR_W       memory word-address width (1..16); addresses wrap modulo 2**ADDR_W
// Ports:
//   clk1, rst_n                  clock (rising edge), asynchronous active-low reset
//   in_valid, in_data, in_ready  byte stream; a byte transfers on in_valid & in_ready
//   mem_we, mem_addr, mem_wdata  one-cycle memory write port
//   core_start                   one-cycle pulse that releases the core from address 0
//   core_halted                  core HALTED flag
//   busy, done, error            loader status
module mips32_prog_loader #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_start,
  input  logic              core_halted,
  output logic              busy,
  output logic              done,
  output logic              error
);

  // 17-bit word index so that count=65535 (and the 2**ADDR_W limit) never aliases
  localparam int unsigned          IDX_W     = 17;
  localparam logic [IDX_W-1:0]     MAX_WORDS = IDX_W'(2 ** ADDR_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_CHK,
    S_START,
    S_RUN,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state;
  logic [1:0]        byte_cnt;
  logic [23:0]       shift_q;
  logic [IDX_W-1:0]  word_idx;
  logic [IDX_W-1:0]  word_cnt;
  logic [ADDR_W-1:0] wr_addr;
  logic              run_armed;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [31:0]       csum;
`endif

  logic        xfer;
  logic        last_byte;
  logic [31:0] word;

  // Current byte completes the word being assembled when it is the 4th of its group
  assign xfer      = in_valid & in_ready;
  assign last_byte = (byte_cnt == 2'd3);
  assign word      = {shift_q, in_data};

  // Loader FSM with registered outputs
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      byte_cnt   <= '0;
      shift_q    <= '0;
      word_idx   <= '0;
      word_cnt   <= '0;
      wr_addr    <= '0;
      run_armed  <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
      in_ready   <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      core_start <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      mem_we     <= 1'b0;
      core_start <= 1'b0;

      // Big-endian packing: earlier bytes shift toward [31:24]
      if (xfer) begin
        shift_q  <= word[23:0];
        byte_cnt <= byte_cnt + 2'd1;
      end

      case (state)
        // Ready for a new image; the first byte is header byte 0
        S_IDLE, S_DONE: begin
          in_ready <= 1'b1;
          if (xfer) begin
            state <= S_HDR;
            done  <= 1'b0;
            busy  <= 1'b1;
          end
        end

        // Header decode on its 4th byte
        S_HDR: begin
          if (xfer && last_byte) begin
            word_cnt <= {1'b0, word[15:0]};
            word_idx <= '0;
            wr_addr  <= ADDR_W'(word[31:16]);
`ifdef PROG_LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
            if ({1'b0, word[15:0]} > MAX_WORDS) begin
              state    <= S_ERR;
              error    <= 1'b1;
              busy     <= 1'b0;
              in_ready <= 1'b0;
            end else if (word[15:0] == 16'd0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
              state      <= S_CHK;
`else
              state      <= S_START;
              core_start <= 1'b1;
              in_ready   <= 1'b0;
`endif
            end else begin
              state <= S_DATA;
            end
          end
        end

        // Data words; the write cycle doubles as the one-cycle input stall
        S_DATA: begin
          if (mem_we) begin
            if (word_idx == word_cnt) begin
`ifdef PROG_LOADER_CHECKSUM_EN
              state      <= S_CHK;
              in_ready   <= 1'b1;
`else
              state      <= S_START;
              core_start <= 1'b1;
`endif
            end else begin
              in_ready <= 1'b1;
            end
          end else if (xfer && last_byte) begin
            mem_we    <= 1'b1;
            mem_addr  <= wr_addr;
            mem_wdata <= word;
            wr_addr   <= wr_addr + ADDR_W'(1);
            word_idx  <= word_idx + IDX_W'(1);
            in_ready  <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum      <= csum ^ word;
`endif
          end
        end

`ifdef PROG_LOADER_CHECKSUM_EN
        // Trailer compare; never written to memory
        S_CHK: begin
          if (xfer && last_byte) begin
            in_ready <= 1'b0;
            if (word == csum) begin
              state      <= S_START;
              core_start <= 1'b1;
            end else begin
              state <= S_ERR;
              error <= 1'b1;
              busy  <= 1'b0;
            end
          end
        end
`endif

        S_START: begin
          state     <= S_RUN;
          run_armed <= 1'b0;
        end

        // First RUN cycle ignores core_halted so a stale HALTED cannot end the run
        S_RUN: begin
          if (!run_armed) begin
            run_armed <= 1'b1;
          end else if (core_halted) begin
            state    <= S_DONE;
            done     <= 1'b1;
            busy     <= 1'b0;
            in_ready <= 1'b1;
          end
        end

        // Sticky until rst_n
        S_ERR: begin
          in_ready <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips32_prog_loader.sv
// tb_mips32_prog_loader: self-checking bench for mips32_prog_loader.
//   Images are described by a table of {base, count, gaps, core delay, expected outcome}
//   records plus random images. A reference model derives the expected write list as
//   (base + i) mod 2**ADDR_W / word i. A small core model raises HALTED a set delay after
//   core_start, and it keeps a stale HALTED through the START cycle and the first RUN cycle.
module tb_mips32_prog_loader;

  localparam int unsigned AW        = 10;
  localparam int unsigned MEM_WORDS = 1 << AW;
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  typedef struct {
    logic [15:0] base;
    logic [15:0] count;
    int          gap;
    int          delay;
    int          mode;   // 0 normal, 1 header error, 2 bad trailer
  } vec_t;

  logic          clk1;
  logic          rst_n;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          core_start;
  logic          core_halted = 1'b1;
  logic          busy;
  logic          done;
  logic          error;

  int  errors;
  int  checks;
  int  gap_pct;
  int  halt_delay;
  int  cyc   = 0;
  int  viol  = 0;
  int  starts = 0;
  logic lag  = 1'b0;
  int  hcnt  = 0;
  wr_t wr_q[$];
  wr_t mon_r;
  logic [31:0] img[$];
  vec_t tbl[7];

  mips32_prog_loader #(.ADDR_W(AW)) dut (
    .clk1        (clk1),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .core_start  (core_start),
    .core_halted (core_halted),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  initial begin
    clk1 = 1'b0;
    forever #5 clk1 = ~clk1;
  end

  always @(posedge clk1) cyc <= cyc + 1;

  // Core model: HALTED clears one cycle after the start pulse, then rises halt_delay later
  always @(posedge clk1) begin
    if (core_start) begin
      lag  <= 1'b1;
      hcnt <= halt_delay;
    end else if (lag) begin
      lag         <= 1'b0;
      core_halted <= 1'b0;
    end else if (hcnt > 0) begin
      hcnt <= hcnt - 1;
      if (hcnt == 1) core_halted <= 1'b1;
    end
  end

  // Write/start monitor plus always-on protocol rules
  always @(negedge clk1) begin
    if (rst_n) begin
      if (mem_we) begin
        mon_r.addr = mem_addr;
        mon_r.data = mem_wdata;
        wr_q.push_back(mon_r);
      end
      if (core_start) starts = starts + 1;
      if (mem_we && core_start) begin
        viol = viol + 1;
        $display("FAIL rule_we_start: mem_we and core_start both high at cycle %0d", cyc);
      end
      if (mem_we && in_ready) begin
        viol = viol + 1;
        $display("FAIL rule_we_ready: in_ready high during write at cycle %0d", cyc);
      end
      if (error && (mem_we || core_start)) begin
        viol = viol + 1;
        $display("FAIL rule_err_quiet: activity in error state at cycle %0d", cyc);
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({in_ready, mem_we, mem_addr, mem_wdata, core_start, busy, done, error});
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int n;
    if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct)
      repeat ($urandom_range(3, 1)) tick();
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    @(negedge clk1);
    while (!in_ready && n < 300) begin
      @(negedge clk1);
      n++;
    end
    check("handshake", 64'(in_ready), 64'd1);
    @(posedge clk1);
    #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 3; k >= 0; k--) send_byte(w[8*k +: 8]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("reset_outs", all_outs(), 64'd0);
    repeat (2) tick();
    check("reset_hold", all_outs(), 64'd0);
    rst_n = 1'b1;
    tick();
    tick();
    check("idle_after_reset", 64'({in_ready, busy, done, error}), 64'b1000);
  endtask

  task automatic run_image(input logic [15:0] base, input logic [15:0] count,
                           input int gap, input int delay, input int mode);
    logic [31:0] x;
    wr_t         e;
    wr_t         exp_q[$];
    int          w0, s0, n, bad, cs;
    gap_pct    = gap;
    halt_delay = delay;
    w0 = wr_q.size();
    s0 = starts;
    while (img.size() < int'(count)) img.push_back($urandom);
    send_word({base, count});
    if (mode == 1) begin
      repeat (5) tick();
      check("hdr_err_error", 64'(error), 64'd1);
      check("hdr_err_flags", 64'({in_ready, busy, done}), 64'd0);
      check("hdr_err_writes", 64'(wr_q.size() - w0), 64'd0);
      check("hdr_err_starts", 64'(starts - s0), 64'd0);
      img.delete();
      return;
    end
    x = 32'd0;
    for (int i = 0; i < int'(count); i++) begin
      e.addr = AW'((int'(base) + i) % MEM_WORDS);
      e.data = img[i];
      exp_q.push_back(e);
      x = x ^ img[i];
      send_word(img[i]);
      check("wr_strobe", 64'({mem_we, in_ready}), 64'b10);
      check("wr_addr", 64'(mem_addr), 64'(e.addr));
      check("wr_data", 64'(mem_wdata), 64'(e.data));
    end
    img.delete();
    if (CSUM) send_word((mode == 2) ? (x ^ 32'h7) : x);
    if (mode == 2) begin
      repeat (3) tick();
      check("csum_err_error", 64'({error, done, busy}), 64'b100);
      check("csum_err_starts", 64'(starts - s0), 64'd0);
      check("csum_err_writes", 64'(wr_q.size() - w0), 64'(count));
      return;
    end
    if (!CSUM && count != 16'd0) tick();
    check("start_pulse", 64'({core_start, mem_we}), 64'b10);
    check("busy_run", 64'({busy, done}), 64'b10);
    cs = cyc;
    n = 0;
    while (!done && n < delay + 20) begin
      tick();
      n++;
    end
    check("done_flags", 64'({done, busy, error, in_ready}), 64'b1001);
    check("done_latency", 64'(cyc - cs), 64'(delay + 3));
    check("start_count", 64'(starts - s0), 64'd1);
    check("wr_count", 64'(wr_q.size() - w0), 64'(exp_q.size()));
    bad = 0;
    for (int i = 0; i < exp_q.size() && (w0 + i) < wr_q.size(); i++) begin
      if (wr_q[w0 + i] != exp_q[i]) begin
        if (bad == 0)
          $display("FAIL wr_list: entry %0d got %0h/%0h expected %0h/%0h", i,
                   wr_q[w0 + i].addr, wr_q[w0 + i].data, exp_q[i].addr, exp_q[i].data);
        bad++;
      end
    end
    check("wr_list_bad", 64'(bad), 64'd0);
  endtask

  initial begin
    int w0;
    errors     = 0;
    checks     = 0;
    gap_pct    = 0;
    halt_delay = 10;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = 8'd0;

    tbl[0] = '{16'h03FE, 16'd3,    0,  10, 0};
    tbl[1] = '{16'h0000, 16'd0,    0,  5,  0};
    tbl[2] = '{16'h0100, 16'd5,    50, 1,  0};
    tbl[3] = '{16'hABCD, 16'd4,    30, 7,  0};
    tbl[4] = '{16'h0005, 16'd1024, 0,  3,  0};
    tbl[5] = '{16'h7FFF, 16'd1,    20, 2,  0};
    tbl[6] = '{16'h0000, 16'h0401, 0,  1,  1};

    repeat (3) @(posedge clk1);
    #1;
    check("reset_outs_init", all_outs(), 64'd0);
    rst_n = 1'b1;
    tick();
    tick();
    check("idle_state", 64'({in_ready, busy, done, error}), 64'b1000);

    // Reference program image
    img = '{32'h28010078, 32'h0c631800, 32'h20220000, 32'h0c631800,
            32'h2842002d, 32'h0c631800, 32'h24220001, 32'h0c000000};
    run_image(16'h0000, 16'd8, 0, 40, 0);

    // Random images, each starting from DONE
    for (int r = 0; r < 6; r++)
      run_image(16'($urandom), 16'($urandom_range(12, 1)), int'($urandom_range(60)),
                int'($urandom_range(30, 1)), 0);

    // Directed table, ending with an oversize header
    for (int t = 0; t < 7; t++)
      run_image(tbl[t].base, tbl[t].count, tbl[t].gap, tbl[t].delay, tbl[t].mode);

    // Error state is sticky
    repeat (20) tick();
    check("err_sticky", 64'({error, in_ready}), 64'b10);
    do_reset();
    check("err_cleared", 64'(error), 64'd0);

    // Reset in the middle of a load
    w0 = wr_q.size();
    gap_pct = 40;
    send_word({16'h0040, 16'd4});
    send_word($urandom);
    send_word($urandom);
    tick();
    check("partial_writes", 64'(wr_q.size() - w0), 64'd2);
    do_reset();
    run_image(16'h0123, 16'd2, 40, 6, 0);

`ifdef PROG_LOADER_CHECKSUM_EN
    img = '{32'h1, 32'h2};
    run_image(16'h0010, 16'd2, 0, 4, 0);
    img = '{32'h1, 32'h2};
    run_image(16'h0010, 16'd2, 0, 4, 2);
    do_reset();
`endif

    check("protocol_rules", 64'(viol), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
